// File: rtl/gcd_engine_pkg.sv
// rtl/gcd_engine_pkg.sv - shared defaults and FSM state encodings for the GCD engine
// Purpose: default operand/counter widths and the engine's FSM state constants.
// Ports: none (package).
package gcd_engine_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_MOD  = 3'd2;
  localparam logic [2:0] ST_SWAP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/gcd_engine_if.sv
// rtl/gcd_engine_if.sv - operand/result handshake bundle of the GCD engine
// Purpose: groups the start/busy handshake, operands and results.
// Signals: start_i, Zahl1_i, Zahl2_i (requester -> engine);
//          busy_o, done_o, gcd_o, step_cnt_o, zero_o (engine -> requester).
// Modports: master = requester side, slave = engine side.
interface gcd_engine_if
  import gcd_engine_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start_i;
  logic [WIDTH-1:0] Zahl1_i;
  logic [WIDTH-1:0] Zahl2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] gcd_o;
  logic [CNT_W-1:0] step_cnt_o;
  logic             zero_o;

  modport master (
    output start_i, Zahl1_i, Zahl2_i,
    input  busy_o, done_o, gcd_o, step_cnt_o, zero_o
  );

  modport slave (
    input  start_i, Zahl1_i, Zahl2_i,
    output busy_o, done_o, gcd_o, step_cnt_o, zero_o
  );

endinterface

// File: rtl/gcd_mod_unit.sv
// rtl/gcd_mod_unit.sv - sequential restoring shift-subtract modulo unit
// Purpose: computes dividend_i mod divisor_i (divisor_i != 0) in WIDTH cycles, MSB first.
// Ports: clk, rst (async active-low), start_i (load operands, first bit processed on the
//        same edge), dividend_i, divisor_i, rem_o (remainder, held until next start),
//        done_o (one-cycle pulse, rem_o valid while it is high).
module gcd_mod_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  // One restoring step; the extra remainder bit holds 2*r+1 < 2*divisor without overflow.
  function automatic logic [WIDTH:0] mod_step(input logic [WIDTH:0]   rem,
                                              input logic             bit_in,
                                              input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    sh = {rem[WIDTH-1:0], bit_in};
    if (sh >= {1'b0, dvs}) begin
      sh = sh - {1'b0, dvs};
    end
    return sh;
  endfunction

  // The first bit is consumed on the start edge so that the pulse lands in the
  // WIDTH-th cycle and the owner can leave its wait state exactly WIDTH edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_i) begin
        r_rem <= mod_step('0, dividend_i[WIDTH-1], divisor_i);
        r_dvd <= {dividend_i[WIDTH-2:0], 1'b0};
        r_dvs <= divisor_i;
        r_cnt <= CW'(WIDTH - 1);
      end else if (r_cnt != '0) begin
        r_rem  <= mod_step(r_rem, r_dvd[WIDTH-1], r_dvs);
        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
        r_cnt  <= r_cnt - CW'(1);
        r_done <= (r_cnt == CW'(1));
      end
    end
  end

  assign rem_o  = r_rem[WIDTH-1:0];
  assign done_o = r_done;

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - self-sequencing Euclid GCD engine
// Purpose: iterates (a,b) <- (b, a mod b) until b == 0 and reports gcd, step count and zero flag.
// Ports: clk, rst (async active-low), bus (gcd_engine_if.slave): start_i, Zahl1_i, Zahl2_i in;
//        busy_o, done_o, gcd_o, step_cnt_o, zero_o out.
module gcd_engine
  import gcd_engine_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  gcd_engine_if.slave bus
);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_gcd;
  logic [CNT_W-1:0] r_step;
  logic             r_done;
  logic             r_zero;

  logic             w_mod_start;
  logic [WIDTH-1:0] w_mod_dvd;
  logic [WIDTH-1:0] w_mod_dvs;
  logic [WIDTH-1:0] w_rem;
  logic             w_mod_done;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // In SWAP the next modulo must run on the post-swap pair (b, r), which is not
  // registered yet, so the sub-unit is fed straight from b and the remainder.
  always_comb begin
    w_mod_start = 1'b0;
    w_mod_dvd   = r_a;
    w_mod_dvs   = r_b;
    if (r_state == ST_LOAD && r_b != '0) begin
      w_mod_start = 1'b1;
    end else if (r_state == ST_SWAP && w_rem != '0) begin
      w_mod_start = 1'b1;
      w_mod_dvd   = r_b;
      w_mod_dvs   = w_rem;
    end
  end

  gcd_mod_unit #(.WIDTH(WIDTH)) u_mod (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_mod_start),
    .dividend_i (w_mod_dvd),
    .divisor_i  (w_mod_dvs),
    .rem_o      (w_rem),
    .done_o     (w_mod_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_gcd   <= '0;
      r_step  <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_a     <= bus.Zahl1_i;
            r_b     <= bus.Zahl2_i;
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_b == '0) begin
            r_gcd   <= r_a;
            r_step  <= r_cnt;
            r_zero  <= (r_a == '0);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MOD;
          end
        end
        ST_MOD: begin
          if (w_mod_done) begin
            r_state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          r_a   <= r_b;
          r_b   <= w_rem;
          r_cnt <= w_cnt_inc;
          if (w_rem == '0) begin
            r_gcd   <= r_b;
            r_step  <= w_cnt_inc;
            r_zero  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MOD;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = (r_state != ST_IDLE);
  assign bus.done_o     = r_done;
  assign bus.gcd_o      = r_gcd;
  assign bus.step_cnt_o = r_step;
  assign bus.zero_o     = r_zero;

endmodule
